// File: rtl/hsv_centroid_if.sv
// Pixel stream, colour window and centroid result bundle for hsv_centroid.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is valid-only and results are single-cycle pulses.
interface hsv_centroid_if #(
    parameter int HSV_BITWIDTH = 8,
    parameter int X_WIDTH      = 11,
    parameter int Y_WIDTH      = 10,
    parameter int CNT_WIDTH    = 20
) ();
    logic                    hsv_valid;
    logic [HSV_BITWIDTH-1:0] h;
    logic [HSV_BITWIDTH-1:0] s;
    logic [HSV_BITWIDTH-1:0] v;
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic                    frame_done;
    logic [HSV_BITWIDTH-1:0] h_lo;
    logic [HSV_BITWIDTH-1:0] h_hi;
    logic [HSV_BITWIDTH-1:0] s_min;
    logic [HSV_BITWIDTH-1:0] v_min;
    logic                    mask;
    logic                    mask_valid;
    logic [X_WIDTH-1:0]      centroid_x;
    logic [Y_WIDTH-1:0]      centroid_y;
    logic [CNT_WIDTH-1:0]    pixel_count;
    logic                    found;
    logic                    centroid_valid;
    logic                    overrun;

    // Upstream side: drives pixels and window, observes results.
    modport master (
        output hsv_valid, h, s, v, x, y, frame_done, h_lo, h_hi, s_min, v_min,
        input  mask, mask_valid, centroid_x, centroid_y, pixel_count, found,
               centroid_valid, overrun
    );

    // Block side.
    modport slave (
        input  hsv_valid, h, s, v, x, y, frame_done, h_lo, h_hi, s_min, v_min,
        output mask, mask_valid, centroid_x, centroid_y, pixel_count, found,
               centroid_valid, overrun
    );
endinterface

// File: rtl/hsv_centroid.sv
// HSV colour-window mask plus per-frame centroid of matching pixels via a serial divider.
// Latency: mask 1 cycle; centroid X_WIDTH+Y_WIDTH+2 cycles after frame_done (2 when nothing matched).
// Backpressure: none; a frame_done arriving mid-division drops that frame's totals and pulses overrun.
module hsv_centroid #(
    parameter int HSV_BITWIDTH = 8,
    parameter int X_WIDTH      = 11,
    parameter int Y_WIDTH      = 10,
    parameter int CNT_WIDTH    = 20
) (
    input  logic            clock,
    input  logic            reset,
    hsv_centroid_if.slave   bus
);
    localparam int SX_W = X_WIDTH + CNT_WIDTH;
    localparam int SY_W = Y_WIDTH + CNT_WIDTH;
    localparam int DV_W = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int BC_W = $clog2(DV_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIV_X = 2'd1;
    localparam logic [1:0] ST_DIV_Y = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic                 hit_h;
    logic                 match;
    logic                 pix_hit;

    logic [CNT_WIDTH-1:0] cnt;
    logic [SX_W-1:0]      sum_x;
    logic [SY_W-1:0]      sum_y;
    logic [CNT_WIDTH-1:0] cnt_fin;
    logic [SX_W-1:0]      sx_fin;
    logic [SY_W-1:0]      sy_fin;

    logic [1:0]           state;
    logic [BC_W-1:0]      bit_cnt;
    logic [CNT_WIDTH-1:0] divisor;
    logic [CNT_WIDTH-1:0] rem;
    logic [DV_W-1:0]      dvd;
    logic [SY_W-1:0]      lat_sy;
    logic [X_WIDTH-1:0]   qx;
    logic [Y_WIDTH-1:0]   qy;

    logic [CNT_WIDTH:0]   trial;
    logic                 take_bit;
    logic [CNT_WIDTH-1:0] rem_nxt;

    // Hue window wraps through red when the low bound exceeds the high bound.
    assign hit_h   = (bus.h_lo <= bus.h_hi) ? ((bus.h >= bus.h_lo) && (bus.h <= bus.h_hi))
                                            : ((bus.h >= bus.h_lo) || (bus.h <= bus.h_hi));
    assign match   = hit_h && (bus.s >= bus.s_min) && (bus.v >= bus.v_min);
    assign pix_hit = bus.hsv_valid && match;

    // Totals including this cycle's pixel; these are what frame_done latches.
    assign cnt_fin = cnt + CNT_WIDTH'(pix_hit);
    assign sx_fin  = sum_x + (pix_hit ? SX_W'(bus.x) : '0);
    assign sy_fin  = sum_y + (pix_hit ? SY_W'(bus.y) : '0);

    // One restoring-division step. The remainder always stays below the divisor, so the
    // subtraction can be done modulo 2^CNT_WIDTH without losing the result.
    assign trial    = {rem, dvd[DV_W-1]};
    assign take_bit = (trial >= {1'b0, divisor});
    assign rem_nxt  = take_bit ? (trial[CNT_WIDTH-1:0] - divisor) : trial[CNT_WIDTH-1:0];

    // Mask path: independent of the centroid FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.mask       <= 1'b0;
            bus.mask_valid <= 1'b0;
        end else begin
            bus.mask       <= match;
            bus.mask_valid <= bus.hsv_valid;
        end
    end

    // Frame accumulators: clear on frame_done so the next frame starts from zero.
    always_ff @(posedge clock) begin
        if (reset || bus.frame_done) begin
            cnt   <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else begin
            cnt   <= cnt_fin;
            sum_x <= sx_fin;
            sum_y <= sy_fin;
        end
    end

    // Centroid FSM and serial divider. The quotient fits its coordinate width (mean <= max
    // coordinate), so the upper dividend bits seed the remainder and only the low
    // coordinate-width bits are shifted through.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            bit_cnt            <= '0;
            divisor            <= '0;
            rem                <= '0;
            dvd                <= '0;
            lat_sy             <= '0;
            qx                 <= '0;
            qy                 <= '0;
            bus.centroid_x     <= '0;
            bus.centroid_y     <= '0;
            bus.pixel_count    <= '0;
            bus.found          <= 1'b0;
            bus.centroid_valid <= 1'b0;
            bus.overrun        <= 1'b0;
        end else begin
            bus.centroid_valid <= 1'b0;
            bus.overrun        <= bus.frame_done && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (bus.frame_done) begin
                        divisor <= cnt_fin;
                        lat_sy  <= sy_fin;
                        rem     <= sx_fin[SX_W-1:X_WIDTH];
                        dvd     <= DV_W'(sx_fin[X_WIDTH-1:0]) << (DV_W - X_WIDTH);
                        bit_cnt <= '0;
                        qx      <= '0;
                        qy      <= '0;
                        state   <= (cnt_fin != '0) ? ST_DIV_X : ST_DONE;
                    end
                end
                ST_DIV_X: begin
                    qx      <= {qx[X_WIDTH-2:0], take_bit};
                    rem     <= rem_nxt;
                    dvd     <= dvd << 1;
                    bit_cnt <= bit_cnt + BC_W'(1);
                    if (bit_cnt == BC_W'(X_WIDTH - 1)) begin
                        rem     <= lat_sy[SY_W-1:Y_WIDTH];
                        dvd     <= DV_W'(lat_sy[Y_WIDTH-1:0]) << (DV_W - Y_WIDTH);
                        bit_cnt <= '0;
                        state   <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    qy      <= {qy[Y_WIDTH-2:0], take_bit};
                    rem     <= rem_nxt;
                    dvd     <= dvd << 1;
                    bit_cnt <= bit_cnt + BC_W'(1);
                    if (bit_cnt == BC_W'(Y_WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.centroid_x     <= qx;
                    bus.centroid_y     <= qy;
                    bus.pixel_count    <= divisor;
                    bus.found          <= (divisor != '0);
                    bus.centroid_valid <= 1'b1;
                    state              <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hsv_centroid.sv
// Directed bench for hsv_centroid with a queue-based scoreboard and an independent monitor.
// Latency: checks mask at +1 cycle, centroid at +23 (+2 for empty frames), overrun at +1.
// Backpressure: none; stimulus is valid-only.
module tb_hsv_centroid;
    logic clock;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;

    typedef struct {
        int cx;
        int cy;
        int cnt;
        int fnd;
        int at;
    } cexp_t;

    cexp_t cq[$];
    int    mq_val[$];
    int    mq_at[$];
    int    oq_at[$];

    hsv_centroid_if #(.HSV_BITWIDTH(8), .X_WIDTH(11), .Y_WIDTH(10), .CNT_WIDTH(20)) bus ();

    hsv_centroid #(.HSV_BITWIDTH(8), .X_WIDTH(11), .Y_WIDTH(10), .CNT_WIDTH(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mask_valid) begin
                if (mq_val.size() == 0) begin
                    chk("mask_unexpected", 1, 0);
                end else begin
                    chk("mask", int'(bus.mask), mq_val.pop_front());
                    chk("mask_cycle", cyc, mq_at.pop_front());
                end
            end
            if (bus.centroid_valid) begin
                if (cq.size() == 0) begin
                    chk("centroid_unexpected", 1, 0);
                end else begin
                    cexp_t e;
                    e = cq.pop_front();
                    chk("centroid_x", int'(bus.centroid_x), e.cx);
                    chk("centroid_y", int'(bus.centroid_y), e.cy);
                    chk("pixel_count", int'(bus.pixel_count), e.cnt);
                    chk("found", int'(bus.found), e.fnd);
                    chk("centroid_cycle", cyc, e.at);
                end
            end
            if (bus.overrun) begin
                if (oq_at.size() == 0) chk("overrun_unexpected", 1, 0);
                else chk("overrun_cycle", cyc, oq_at.pop_front());
            end
        end
    end

    // One cycle of stimulus; caller is just past a rising edge.
    task automatic drive(input bit pv, input int hh, input int ss, input int vv,
                         input int xx, input int yy, input bit fd, input int exp_mask);
        bus.hsv_valid  = pv;
        bus.h          = 8'(hh);
        bus.s          = 8'(ss);
        bus.v          = 8'(vv);
        bus.x          = 11'(xx);
        bus.y          = 10'(yy);
        bus.frame_done = fd;
        if (pv) begin
            mq_val.push_back(exp_mask);
            mq_at.push_back(cyc + 1);
        end
        @(posedge clock); #1;
        bus.hsv_valid  = 1'b0;
        bus.frame_done = 1'b0;
        bus.h = '0; bus.s = '0; bus.v = '0; bus.x = '0; bus.y = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic expect_c(input int cx, input int cy, input int cnt, input int fnd, input int lat);
        cexp_t e;
        e.cx = cx; e.cy = cy; e.cnt = cnt; e.fnd = fnd; e.at = cyc + lat;
        cq.push_back(e);
    endtask

    task automatic set_win(input int lo, input int hi, input int smin, input int vmin);
        bus.h_lo = 8'(lo); bus.h_hi = 8'(hi); bus.s_min = 8'(smin); bus.v_min = 8'(vmin);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.hsv_valid = 1'b0; bus.frame_done = 1'b0;
        bus.h = '0; bus.s = '0; bus.v = '0; bus.x = '0; bus.y = '0;
        set_win(30, 50, 128, 128);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_mask", int'(bus.mask), 0);
        chk("rst_mask_valid", int'(bus.mask_valid), 0);
        chk("rst_centroid_x", int'(bus.centroid_x), 0);
        chk("rst_centroid_y", int'(bus.centroid_y), 0);
        chk("rst_pixel_count", int'(bus.pixel_count), 0);
        chk("rst_found", int'(bus.found), 0);
        chk("rst_centroid_valid", int'(bus.centroid_valid), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        @(posedge clock); #1;

        // Empty frame: zero path at t+2
        expect_c(0, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(5);

        // Single pixel
        drive(1, 40, 200, 200, 100, 50, 0, 1);
        expect_c(100, 50, 1, 1, 23);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(30);

        // Truncation: sums 32/13 over 3
        drive(1, 40, 200, 200, 10, 4, 0, 1);
        drive(1, 40, 200, 200, 11, 4, 0, 1);
        drive(1, 40, 200, 200, 11, 5, 0, 1);
        expect_c(10, 4, 3, 1, 23);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(30);

        // Hue wrap window 240..10
        set_win(240, 10, 128, 128);
        drive(1, 250, 200, 200, 1, 1, 0, 1);
        drive(1, 5,   200, 200, 3, 3, 0, 1);
        drive(1, 128, 200, 200, 9, 9, 0, 0);
        drive(1, 250, 100, 200, 9, 9, 0, 0);
        drive(1, 5,   200, 50,  9, 9, 0, 0);
        drive(1, 10,  128, 128, 5, 2, 0, 1);
        drive(1, 11,  200, 200, 9, 9, 0, 0);
        drive(1, 239, 200, 200, 9, 9, 0, 0);
        expect_c(3, 2, 3, 1, 23);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(30);

        // frame_done coincident with a matching pixel; next frame starts at t+1
        set_win(30, 50, 128, 128);
        expect_c(7, 3, 1, 1, 23);
        drive(1, 40, 200, 200, 7, 3, 1, 1);
        drive(1, 40, 200, 200, 20, 20, 0, 1);
        idle(30);
        expect_c(20, 20, 1, 1, 23);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(30);

        // Overrun: second frame_done at t+5 is dropped, first result still at t+23
        drive(1, 40, 200, 200, 8, 8, 0, 1);
        expect_c(8, 8, 1, 1, 23);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        oq_at.push_back(cyc + 1);
        drive(1, 40, 200, 200, 30, 30, 1, 1);
        idle(30);
        // Accumulators were cleared by the dropped frame_done: next frame is empty
        expect_c(0, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        idle(10);

        chk("mask_queue_empty", mq_val.size(), 0);
        chk("centroid_queue_empty", cq.size(), 0);
        chk("overrun_queue_empty", oq_at.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
